// File: rtl/hr_pkg.sv
// Shared widths, FSM state and FIFO entry layout for the HyperRAM DQ write gearbox.
package hr_pkg;

  localparam int HR_DQ_W    = 8;
  localparam int HR_WORD_W  = 32;
  localparam int HR_MASK_W  = HR_WORD_W / HR_DQ_W;

  typedef enum logic {
    IDLE,
    SEND
  } state_t;

  typedef struct packed {
    logic [HR_WORD_W-1:0] data;
    logic [HR_MASK_W-1:0] mask;
    logic                 last;
  } fifo_entry_t;

endpackage

// File: rtl/hr_dq_tx_gearbox_if.sv
// Write-word stream from the controller into the DQ gearbox.
interface hr_dq_tx_gearbox_if;
  import hr_pkg::*;

  logic                 s_valid;
  logic                 s_ready;
  logic [HR_WORD_W-1:0] s_data;
  logic [HR_MASK_W-1:0] s_mask;
  logic                 s_last;

  modport master (output s_valid, s_data, s_mask, s_last, input s_ready);
  modport slave  (input s_valid, s_data, s_mask, s_last, output s_ready);

endinterface

// File: rtl/hr_sync_fifo.sv
// Synchronous FIFO; pointers carry one extra wrap bit so full/empty/count come from pointer math.
module hr_sync_fifo #(
  parameter int DEPTH = 4,
  parameter int WIDTH = 37
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic                   push,
  input  logic [WIDTH-1:0]       wdata,
  input  logic                   pop,
  output logic [WIDTH-1:0]       rdata,
  output logic                   full,
  output logic                   empty,
  output logic [$clog2(DEPTH):0] count
);

  localparam int AW = $clog2(DEPTH);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW:0]      wr_ptr;
  logic [AW:0]      rd_ptr;
  logic             do_push;
  logic             do_pop;

  assign full    = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
  assign empty   = (wr_ptr == rd_ptr);
  assign count   = wr_ptr - rd_ptr;
  assign do_push = push && !full;
  assign do_pop  = pop && !empty;
  assign rdata   = mem[rd_ptr[AW-1:0]];

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + (AW+1)'(1);
      if (do_pop)  rd_ptr <= rd_ptr + (AW+1)'(1);
    end
  end

  // Storage is left unreset; entries are only read once the pointers say they are valid.
  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr[AW-1:0]] <= wdata;
  end

endmodule

// File: rtl/hr_dq_tx_gearbox.sv
// Splits buffered 32-bit write words into two rise/fall DQ byte pairs per word for the
// SAME_EDGE ODDRs, with RWDS byte masks, DQ output enable and masked filler on underrun.
module hr_dq_tx_gearbox
  import hr_pkg::*;
#(
  parameter int DEPTH = 4,
  parameter int PRIME = 1
) (
  input  logic                clk,
  input  logic                reset,
  hr_dq_tx_gearbox_if.slave   wr,
  output logic [HR_DQ_W-1:0]  dq_ris,
  output logic [HR_DQ_W-1:0]  dq_fal,
  output logic                rwds_ris,
  output logic                rwds_fal,
  output logic                dq_oe,
  output logic                busy,
  output logic                underrun,
  input  logic                clr_underrun
);

  localparam int AW = $clog2(DEPTH);
  localparam logic [AW:0] PRIME_CNT = PRIME[AW:0];

  state_t      state;
  logic        phase;
  fifo_entry_t wentry;
  fifo_entry_t head;
  logic [AW:0] count;
  logic [AW:0] last_cnt;
  logic        full;
  logic        empty;
  logic        push;
  logic        pop;
  logic        start;

  assign wr.s_ready = !full;
  assign push       = wr.s_valid && !full;
  assign pop        = (state == SEND) && phase && !empty;
  assign wentry     = '{data: wr.s_data, mask: wr.s_mask, last: wr.s_last};
  assign start      = (count >= PRIME_CNT) || (last_cnt != '0);
  assign busy       = (state != IDLE) || !empty;

  hr_sync_fifo #(
    .DEPTH (DEPTH),
    .WIDTH ($bits(fifo_entry_t))
  ) u_fifo (
    .clk   (clk),
    .reset (reset),
    .push  (push),
    .wdata (wentry),
    .pop   (pop),
    .rdata (head),
    .full  (full),
    .empty (empty),
    .count (count)
  );

  // Number of buffered words flagged last, so a short burst can start below PRIME.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      last_cnt <= '0;
    end else begin
      case ({push && wentry.last, pop && head.last})
        2'b10:   last_cnt <= last_cnt + (AW+1)'(1);
        2'b01:   last_cnt <= last_cnt - (AW+1)'(1);
        default: last_cnt <= last_cnt;
      endcase
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state    <= IDLE;
      phase    <= 1'b0;
      dq_ris   <= '0;
      dq_fal   <= '0;
      rwds_ris <= 1'b0;
      rwds_fal <= 1'b0;
      dq_oe    <= 1'b0;
      underrun <= 1'b0;
    end else begin
      dq_ris   <= '0;
      dq_fal   <= '0;
      rwds_ris <= 1'b0;
      rwds_fal <= 1'b0;
      dq_oe    <= 1'b0;
      if (clr_underrun) underrun <= 1'b0;
      case (state)
        IDLE: begin
          phase <= 1'b0;
          if (start) state <= SEND;
        end
        SEND: begin
          if (!phase) begin
            // Word boundary with nothing buffered: drive a fully masked filler beat.
            if (empty) begin
              dq_oe    <= 1'b1;
              rwds_ris <= 1'b1;
              rwds_fal <= 1'b1;
              underrun <= 1'b1;
            end else begin
              dq_ris   <= head.data[31:24];
              dq_fal   <= head.data[23:16];
              rwds_ris <= head.mask[3];
              rwds_fal <= head.mask[2];
              dq_oe    <= 1'b1;
              phase    <= 1'b1;
            end
          end else begin
            dq_ris   <= head.data[15:8];
            dq_fal   <= head.data[7:0];
            rwds_ris <= head.mask[1];
            rwds_fal <= head.mask[0];
            dq_oe    <= 1'b1;
            phase    <= 1'b0;
            if (head.last) state <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_hr_dq_tx_gearbox.sv
// Directed bench: one gearbox with PRIME=1 for burst/underrun/reset cases, one with PRIME=4 for fill-up.
module tb_hr_dq_tx_gearbox;
  import hr_pkg::*;

  typedef struct packed {
    logic       oe;
    logic [7:0] ris;
    logic [7:0] fal;
    logic       rr;
    logic       rf;
  } smp_t;

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic       clr_a = 1'b0;
  logic       clr_b = 1'b0;
  logic [7:0] ris_a, fal_a, ris_b, fal_b;
  logic       rr_a, rf_a, oe_a, busy_a, und_a;
  logic       rr_b, rf_b, oe_b, busy_b, und_b;

  int   checks = 0;
  int   failures = 0;
  smp_t log_a[$];
  smp_t log_b[$];

  hr_dq_tx_gearbox_if ifa ();
  hr_dq_tx_gearbox_if ifb ();

  hr_dq_tx_gearbox #(.DEPTH(4), .PRIME(1)) dut_a (
    .clk(clk), .reset(reset), .wr(ifa),
    .dq_ris(ris_a), .dq_fal(fal_a), .rwds_ris(rr_a), .rwds_fal(rf_a),
    .dq_oe(oe_a), .busy(busy_a), .underrun(und_a), .clr_underrun(clr_a)
  );

  hr_dq_tx_gearbox #(.DEPTH(4), .PRIME(4)) dut_b (
    .clk(clk), .reset(reset), .wr(ifb),
    .dq_ris(ris_b), .dq_fal(fal_b), .rwds_ris(rr_b), .rwds_fal(rf_b),
    .dq_oe(oe_b), .busy(busy_b), .underrun(und_b), .clr_underrun(clr_b)
  );

  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("[TB] FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "[TB] watchdog expired");
  end

  task automatic check_output(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("[TB] FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic smp_t mk(input logic oe, input logic [7:0] r, input logic [7:0] f,
                              input logic rr, input logic rf);
    mk = {oe, r, f, rr, rf};
  endfunction

  function automatic smp_t cur_a();
    cur_a = {oe_a, ris_a, fal_a, rr_a, rf_a};
  endfunction

  function automatic smp_t at_a(input int k);
    if (k < log_a.size()) return log_a[k];
    return 'x;
  endfunction

  function automatic smp_t at_b(input int k);
    if (k < log_b.size()) return log_b[k];
    return 'x;
  endfunction

  // One clock: wait for the edge, step off it, record both output sets.
  task automatic tick();
    @(posedge clk);
    #1;
    log_a.push_back({oe_a, ris_a, fal_a, rr_a, rf_a});
    log_b.push_back({oe_b, ris_b, fal_b, rr_b, rf_b});
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) tick();
  endtask

  task automatic fill_logs(input int n);
    for (int i = 0; i < 60 && (log_a.size() < n || log_b.size() < n); i++) tick();
  endtask

  // Hold one word on the stream until it is accepted, returning how many edges it took.
  task automatic apply_stimulus(input bit sel_b, input logic [31:0] d, input logic [3:0] m,
                                input logic l, output int waited);
    logic rdy;
    waited = 0;
    if (sel_b) begin
      ifb.s_valid = 1'b1; ifb.s_data = d; ifb.s_mask = m; ifb.s_last = l;
    end else begin
      ifa.s_valid = 1'b1; ifa.s_data = d; ifa.s_mask = m; ifa.s_last = l;
    end
    do begin
      rdy = sel_b ? ifb.s_ready : ifa.s_ready;
      tick();
      waited++;
    end while (!rdy && waited < 20);
    check_output("push_accept", 32'(rdy), 32'd1);
    ifa.s_valid = 1'b0;
    ifb.s_valid = 1'b0;
  endtask

  initial begin
    int w;
    logic [31:0] d;
    logic [3:0]  m;
    logic [31:0] bw [5];

    ifa.s_valid = 1'b0; ifa.s_data = '0; ifa.s_mask = '0; ifa.s_last = 1'b0;
    ifb.s_valid = 1'b0; ifb.s_data = '0; ifb.s_mask = '0; ifb.s_last = 1'b0;

    // Reset release with no stimulus.
    idle(3);
    reset = 1'b0;
    idle(2);
    check_output("rst_outputs", 32'(cur_a()), 32'(mk(0, 8'h00, 8'h00, 0, 0)));
    check_output("rst_ready", 32'(ifa.s_ready), 32'd1);
    check_output("rst_busy", 32'(busy_a), 32'd0);
    check_output("rst_underrun", 32'(und_a), 32'd0);
    check_output("rst_ready_b", 32'(ifb.s_ready), 32'd1);

    // Single last word: output two clocks after accept, for exactly two clocks.
    log_a.delete();
    apply_stimulus(0, 32'hA1B2C3D4, 4'b0000, 1'b1, w);
    fill_logs(6);
    check_output("single_n1", 32'(at_a(1)), 32'(mk(0, 8'h00, 8'h00, 0, 0)));
    check_output("single_hi", 32'(at_a(2)), 32'(mk(1, 8'hA1, 8'hB2, 0, 0)));
    check_output("single_lo", 32'(at_a(3)), 32'(mk(1, 8'hC3, 8'hD4, 0, 0)));
    check_output("single_end", 32'(at_a(4)), 32'(mk(0, 8'h00, 8'h00, 0, 0)));
    check_output("single_busy", 32'(busy_a), 32'd0);

    // Eight-word burst with a masked word 3; FIFO fills and stalls the stream.
    log_a.delete();
    for (int i = 1; i <= 8; i++) begin
      d = {4'(i), 4'h1, 4'(i), 4'h2, 4'(i), 4'h3, 4'(i), 4'h4};
      m = (i == 3) ? 4'b0110 : 4'b0000;
      apply_stimulus(0, d, m, (i == 8), w);
    end
    fill_logs(20);
    check_output("burst_pre", 32'(at_a(1).oe), 32'd0);
    for (int k = 0; k < 16; k++) begin
      logic [3:0] wi;
      logic [3:0] mm;
      wi = 4'(k / 2 + 1);
      mm = (wi == 4'd3) ? 4'b0110 : 4'b0000;
      if (k % 2 == 0)
        check_output("burst_hi", 32'(at_a(2 + k)), 32'(mk(1, {wi, 4'h1}, {wi, 4'h2}, mm[3], mm[2])));
      else
        check_output("burst_lo", 32'(at_a(2 + k)), 32'(mk(1, {wi, 4'h3}, {wi, 4'h4}, mm[1], mm[0])));
    end
    check_output("burst_end", 32'(at_a(18)), 32'(mk(0, 8'h00, 8'h00, 0, 0)));
    check_output("burst_no_underrun", 32'(und_a), 32'd0);

    // Three words, stream gap, then a last word: four masked filler beats.
    log_a.delete();
    apply_stimulus(0, 32'hC0C1C2C3, 4'b0000, 1'b0, w);
    apply_stimulus(0, 32'hD0D1D2D3, 4'b0000, 1'b0, w);
    apply_stimulus(0, 32'hE0E1E2E3, 4'b0000, 1'b0, w);
    idle(8);
    apply_stimulus(0, 32'hF0F1F2F3, 4'b0000, 1'b1, w);
    fill_logs(16);
    check_output("gap_w3_hi", 32'(at_a(6)), 32'(mk(1, 8'hE0, 8'hE1, 0, 0)));
    check_output("gap_w3_lo", 32'(at_a(7)), 32'(mk(1, 8'hE2, 8'hE3, 0, 0)));
    for (int k = 8; k < 12; k++)
      check_output("gap_filler", 32'(at_a(k)), 32'(mk(1, 8'h00, 8'h00, 1, 1)));
    check_output("gap_w4_hi", 32'(at_a(12)), 32'(mk(1, 8'hF0, 8'hF1, 0, 0)));
    check_output("gap_w4_lo", 32'(at_a(13)), 32'(mk(1, 8'hF2, 8'hF3, 0, 0)));
    check_output("gap_end", 32'(at_a(14)), 32'(mk(0, 8'h00, 8'h00, 0, 0)));
    check_output("underrun_set", 32'(und_a), 32'd1);
    clr_a = 1'b1;
    tick();
    clr_a = 1'b0;
    check_output("underrun_clr", 32'(und_a), 32'd0);

    // Reset during phase 1 of word 2, then a clean burst.
    log_a.delete();
    apply_stimulus(0, 32'h12345678, 4'b0000, 1'b0, w);
    apply_stimulus(0, 32'h9ABCDEF0, 4'b0000, 1'b0, w);
    apply_stimulus(0, 32'h0F1E2D3C, 4'b0000, 1'b1, w);
    idle(3);
    check_output("mid_w2_lo", 32'(at_a(5)), 32'(mk(1, 8'hDE, 8'hF0, 0, 0)));
    reset = 1'b1;
    #1;
    check_output("mid_rst_out", 32'(cur_a()), 32'(mk(0, 8'h00, 8'h00, 0, 0)));
    check_output("mid_rst_busy", 32'(busy_a), 32'd0);
    check_output("mid_rst_ready", 32'(ifa.s_ready), 32'd1);
    tick();
    reset = 1'b0;
    tick();
    check_output("post_rst_busy", 32'(busy_a), 32'd0);
    log_a.delete();
    apply_stimulus(0, 32'h55AA33CC, 4'b0000, 1'b1, w);
    fill_logs(5);
    check_output("post_rst_hi", 32'(at_a(2)), 32'(mk(1, 8'h55, 8'hAA, 0, 0)));
    check_output("post_rst_lo", 32'(at_a(3)), 32'(mk(1, 8'h33, 8'hCC, 0, 0)));
    check_output("post_rst_end", 32'(at_a(4)), 32'(mk(0, 8'h00, 8'h00, 0, 0)));

    // PRIME=4: fill the FIFO, stall the fifth word, then check word order.
    bw[0] = 32'hA0A1A2A3;
    bw[1] = 32'hB0B1B2B3;
    bw[2] = 32'hC4C5C6C7;
    bw[3] = 32'hD4D5D6D7;
    bw[4] = 32'hE8E9EAEB;
    log_b.delete();
    for (int j = 0; j < 4; j++) apply_stimulus(1, bw[j], 4'b0000, 1'b0, w);
    check_output("full_ready", 32'(ifb.s_ready), 32'd0);
    apply_stimulus(1, bw[4], 4'b0000, 1'b1, w);
    check_output("fifth_wait", 32'(w), 32'd4);
    fill_logs(16);
    check_output("prime_start", 32'(at_b(4)), 32'(mk(0, 8'h00, 8'h00, 0, 0)));
    for (int j = 0; j < 5; j++) begin
      check_output("prime_hi", 32'(at_b(5 + 2 * j)), 32'(mk(1, bw[j][31:24], bw[j][23:16], 0, 0)));
      check_output("prime_lo", 32'(at_b(6 + 2 * j)), 32'(mk(1, bw[j][15:8], bw[j][7:0], 0, 0)));
    end
    check_output("prime_end", 32'(at_b(15)), 32'(mk(0, 8'h00, 8'h00, 0, 0)));
    check_output("prime_busy", 32'(busy_b), 32'd0);
    check_output("prime_underrun", 32'(und_b), 32'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
